// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit address / 8-bit data memory bus among NREQ requesters.
// Optional macro BUS_ARB_VSYNC_PRIO_EN: requester 0 wins outright while vsync is high.
module bus_arbiter #(
  parameter int NREQ   = 3,
  parameter int RD_LAT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [16*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]    req_wdata,
  input  logic                 vsync,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ack,
  output logic [7:0]           rdata,
  output logic [15:0]          mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_rw,
  input  logic [7:0]           mem_rdata
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUS, WAIT, ACK} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            mem_rw_q, mem_rw_d;

  logic [15:0] addr_a  [NREQ];
  logic [7:0]  wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[16*g +: 16];
    assign wdata_a[g] = req_wdata[8*g +: 8];
  end

  logic [LW-1:0] win;
  logic [LW-1:0] idx;
  logic          found;
  logic          rr_upd;

  // Circular search starting just after the previous winner.
  always_comb begin
    win    = last_q;
    idx    = '0;
    found  = 1'b0;
    rr_upd = 1'b1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef BUS_ARB_VSYNC_PRIO_EN
    // Vsync priority leaves the pointer alone so fairness resumes afterwards.
    if (vsync && req[0]) begin
      win    = '0;
      rr_upd = 1'b0;
    end
`endif
  end

`ifndef BUS_ARB_VSYNC_PRIO_EN
  logic unused_vsync;
  assign unused_vsync = vsync;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    ack_d       = ack_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d    = mem_rw_q;
    case (state_q)
      IDLE: begin
        grant_d  = '0;
        ack_d    = '0;
        mem_rw_d = 1'b0;
        if (|req) begin
          grant_d[win] = 1'b1;
          mem_addr_d   = addr_a[win];
          mem_wdata_d  = wdata_a[win];
          mem_rw_d     = req_rw[win];
          if (rr_upd) last_d = win;
          state_d = BUS;
        end
      end
      BUS: begin
        // mem_rw_q still carries the direction latched at arbitration.
        mem_rw_d = 1'b0;
        if (mem_rw_q) begin
          ack_d   = grant_q;
          state_d = ACK;
        end else if (RD_LAT == 0) begin
          rdata_d = mem_rdata;
          ack_d   = grant_q;
          state_d = ACK;
        end else begin
          cnt_d   = 2'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          ack_d   = grant_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        ack_d   = '0;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= LW'(NREQ - 1);
      cnt_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = mem_rw_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (RD_LAT 0 and 2) share stimulus and are compared
// every cycle against a transaction-timeline model, plus directed scenario checks.
module tb_bus_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 16 * NREQ;
  localparam int DW   = 8 * NREQ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            vsync;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_rw;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [7:0]      mem_rdata;

  logic [NREQ-1:0] grant_o     [2];
  logic [NREQ-1:0] ack_o       [2];
  logic [7:0]      rdata_o     [2];
  logic [15:0]     mem_addr_o  [2];
  logic [7:0]      mem_wdata_o [2];
  logic            mem_rw_o    [2];

  bus_arbiter #(.NREQ(NREQ), .RD_LAT(0)) u_lat0 (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .vsync(vsync), .grant(grant_o[0]), .ack(ack_o[0]),
    .rdata(rdata_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
    .mem_rw(mem_rw_o[0]), .mem_rdata(mem_rdata)
  );

  bus_arbiter #(.NREQ(NREQ), .RD_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .vsync(vsync), .grant(grant_o[1]), .ack(ack_o[1]),
    .rdata(rdata_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
    .mem_rw(mem_rw_o[1]), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Model: each instance is either idle (m_p == 0) or at cycle m_p of an m_len-cycle transaction.
  int          lat_of [2] = '{0, 2};
  int          m_p    [2];
  int          m_len  [2];
  int          m_own  [2];
  int          m_last [2];
  logic        m_rw   [2];
  logic [15:0] e_addr [2];
  logic [7:0]  e_wdata[2];
  logic [7:0]  e_rdata[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit req_bit(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & NREQ'(1)) != '0;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] g);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (req_bit(g, i)) r = i;
    return r;
  endfunction

  task automatic model_step(input int d);
    int w;
    if (reset) begin
      m_p[d] = 0; m_last[d] = NREQ - 1;
      e_addr[d] = '0; e_wdata[d] = '0; e_rdata[d] = '0;
      return;
    end
    if (m_p[d] == 0) begin
      if (req != '0) begin
        w = -1;
`ifdef BUS_ARB_VSYNC_PRIO_EN
        if (vsync && req_bit(req, 0)) w = 0;
`endif
        if (w < 0) begin
          for (int k = 1; k <= NREQ; k++)
            if (w < 0 && req_bit(req, (m_last[d] + k) % NREQ)) w = (m_last[d] + k) % NREQ;
          m_last[d] = w;
        end
        m_own[d]   = w;
        m_rw[d]    = req_bit(req_rw, w);
        m_len[d]   = m_rw[d] ? 2 : 2 + lat_of[d];
        e_addr[d]  = 16'(req_addr >> (16 * w));
        e_wdata[d] = 8'(req_wdata >> (8 * w));
        m_p[d]     = 1;
      end
    end else begin
      m_p[d]++;
      if (m_p[d] > m_len[d]) m_p[d] = 0;
      else if (m_p[d] == m_len[d] && !m_rw[d]) e_rdata[d] = mem_rdata;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [NREQ-1:0] eg;
      logic [NREQ-1:0] ea;
      eg = (m_p[d] > 0) ? (NREQ'(1) << m_own[d]) : '0;
      ea = (m_p[d] > 0 && m_p[d] == m_len[d]) ? eg : '0;
      check($sformatf("u%0d grant", d), 32'(grant_o[d]), 32'(eg));
      check($sformatf("u%0d ack", d), 32'(ack_o[d]), 32'(ea));
      check($sformatf("u%0d mem_rw", d), 32'(mem_rw_o[d]), 32'(m_p[d] == 1 && m_rw[d]));
      check($sformatf("u%0d mem_addr", d), 32'(mem_addr_o[d]), 32'(e_addr[d]));
      check($sformatf("u%0d mem_wdata", d), 32'(mem_wdata_o[d]), 32'(e_wdata[d]));
      check($sformatf("u%0d rdata", d), 32'(rdata_o[d]), 32'(e_rdata[d]));
      check($sformatf("u%0d grant onehot", d), 32'($countones(grant_o[d]) <= 1), 32'(1));
    end
  endtask

  // Inputs are already set; advance one edge and compare just after it.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_req(input int i, input logic rw, input logic [15:0] a, input logic [7:0] wd);
    req_rw    = (req_rw & ~(NREQ'(1) << i)) | (NREQ'(rw) << i);
    req_addr  = (req_addr & ~(AW'(16'hFFFF) << (16 * i))) | (AW'(a) << (16 * i));
    req_wdata = (req_wdata & ~(DW'(8'hFF) << (8 * i))) | (DW'(wd) << (8 * i));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  int exp_v [7];

  initial begin
    reset = 1'b1; vsync = 1'b0; req = '0; req_rw = '0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0;
    for (int d = 0; d < 2; d++) begin
      m_p[d] = 0; m_len[d] = 2; m_own[d] = 0; m_last[d] = NREQ - 1; m_rw[d] = 1'b0;
      e_addr[d] = '0; e_wdata[d] = '0; e_rdata[d] = '0;
    end

    do_reset();
    check("reset grant", 32'(grant_o[0]), 32'(0));
    check("reset mem_addr", 32'(mem_addr_o[1]), 32'(0));

    // Single write from requester 0.
    set_req(0, 1'b1, 16'hEFF8, 8'h2A);
    req = 3'b001;
    cycle();
    check("wr strobe", 32'(mem_rw_o[0]), 32'(1));
    check("wr addr", 32'(mem_addr_o[0]), 32'(16'hEFF8));
    check("wr data", 32'(mem_wdata_o[0]), 32'(8'h2A));
    req = '0;
    cycle();
    check("wr ack", 32'(ack_o[0]), 32'(3'b001));
    check("wr strobe off", 32'(mem_rw_o[0]), 32'(0));
    cycle();
    check("wr grant off", 32'(grant_o[0]), 32'(0));
    check("wr ack off", 32'(ack_o[0]), 32'(0));

    // Read from requester 1 at both latencies.
    do_reset();
    set_req(1, 1'b0, 16'h0000, 8'h00);
    mem_rdata = 8'h55;
    req = 3'b010;
    cycle();
    req = '0;
    cycle();
    check("rd lat0 ack", 32'(ack_o[0]), 32'(3'b010));
    check("rd lat0 rdata", 32'(rdata_o[0]), 32'(8'h55));
    check("rd lat2 no ack yet", 32'(ack_o[1]), 32'(0));
    cycle();
    cycle();
    check("rd lat2 ack", 32'(ack_o[1]), 32'(3'b010));
    check("rd lat2 rdata", 32'(rdata_o[1]), 32'(8'h55));
    cycle();

    // All three requesters writing continuously.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(16'h1000 + i), 8'(i + 1));
    req = 3'b111;
    for (int t = 0; t < 18; t++) begin
      cycle();
      if (t % 3 == 0) check($sformatf("rr order %0d", t / 3), 32'(oh_idx(grant_o[0])), 32'((t / 3) % 3));
    end

    // Reset during the BUS cycle of a write.
    do_reset();
    set_req(0, 1'b1, 16'h1234, 8'h77);
    req = 3'b001;
    cycle();
    reset = 1'b1;
    cycle();
    check("midrst mem_rw", 32'(mem_rw_o[0]), 32'(0));
    check("midrst grant", 32'(grant_o[0]), 32'(0));
    check("midrst ack", 32'(ack_o[0]), 32'(0));
    reset = 1'b0;
    cycle();
    check("postrst grant", 32'(grant_o[0]), 32'(3'b001));
    req = '0;
    repeat (3) cycle();

    // Vsync priority window in the middle of continuous requests.
`ifdef BUS_ARB_VSYNC_PRIO_EN
    exp_v = '{0, 0, 0, 0, 1, 2, 0};
`else
    exp_v = '{0, 1, 2, 0, 1, 2, 0};
`endif
    do_reset();
    req = 3'b111;
    for (int t = 0; t < 21; t++) begin
      vsync = (t >= 3 && t < 12);
      cycle();
      if (t % 3 == 0) check($sformatf("vsync order %0d", t / 3), 32'(oh_idx(grant_o[0])), 32'(exp_v[t / 3]));
    end
    vsync = 1'b0;

    // Address changed by the owner after arbitration must not reach the bus.
    do_reset();
    set_req(2, 1'b0, 16'hF003, 8'h00);
    req = 3'b100;
    cycle();
    set_req(2, 1'b0, 16'hF005, 8'h00);
    req = '0;
    for (int t = 0; t < 4; t++) begin
      cycle();
      check("addr hold lat0", 32'(mem_addr_o[0]), 32'(16'hF003));
      check("addr hold lat2", 32'(mem_addr_o[1]), 32'(16'hF003));
    end

    // Randomized traffic, occasional reset.
    for (int t = 0; t < 600; t++) begin
      reset     = ($urandom_range(0, 63) == 0);
      req       = NREQ'($urandom);
      req_rw    = NREQ'($urandom);
      req_addr  = AW'({$urandom, $urandom});
      req_wdata = DW'($urandom);
      mem_rdata = 8'($urandom);
      vsync     = 1'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
